// File: rtl/bsram_arb_pkg.sv
// Shared types and constants for the BSRAM port arbiter: FSM state encoding,
// master index assignments and the tag-width helper.
package bsram_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_t;

    localparam int MASTER_DEMOD = 0;
    localparam int MASTER_FFT   = 1;
    localparam int MASTER_OFDM  = 2;

    // Ceiling log2, never below 1 so a tag field always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        result = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/bsram_read_tag_pipe.sv
// Shift register of {valid, owner tag} that runs alongside the BSRAM read
// latency and decodes the final stage into per-master rvalid strobes.
module bsram_read_tag_pipe #(
    parameter int DEPTH       = 2,
    parameter int TAG_W       = 2,
    parameter int NUM_MASTERS = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    input  logic [TAG_W-1:0]       in_tag,
    output logic [NUM_MASTERS-1:0] rvalid,
    output logic                   any_valid
);

    logic [DEPTH-1:0] valid_vec;
    logic [TAG_W-1:0] tag_vec [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            logic             valid_in;
            logic [TAG_W-1:0] tag_in;
            logic             valid_reg;
            logic [TAG_W-1:0] tag_reg;

            if (gi == 0) begin : g_head
                assign valid_in = in_valid;
                assign tag_in   = in_tag;
            end else begin : g_body
                assign valid_in = valid_vec[gi-1];
                assign tag_in   = tag_vec[gi-1];
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    valid_reg <= 1'b0;
                    tag_reg   <= '0;
                end else begin
                    valid_reg <= valid_in;
                    tag_reg   <= tag_in;
                end
            end

            assign valid_vec[gi] = valid_reg;
            assign tag_vec[gi]   = tag_reg;
        end

        // Only the last stage lines up with ram_dout.
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_decode
            assign rvalid[gi] = valid_vec[DEPTH-1] && (tag_vec[DEPTH-1] == TAG_W'(gi));
        end
    endgenerate

    assign any_valid = |valid_vec;

endmodule

// File: rtl/bsram_port_arbiter.sv
// Req/grant arbiter placing NUM_MASTERS masters onto one single-port BSRAM.
// Define BSRAM_ARB_ROUND_ROBIN_EN for round-robin; otherwise lowest index wins.
module bsram_port_arbiter
    import bsram_arb_pkg::*;
#(
    parameter int NUM_MASTERS  = 3,
    parameter int ADDR_WIDTH   = 11,
    parameter int DATA_WIDTH   = 32,
    parameter int READ_LATENCY = 2
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic [NUM_MASTERS-1:0]            m_req,
    output logic [NUM_MASTERS-1:0]            m_grant,
    input  logic [NUM_MASTERS-1:0]            m_ce,
    input  logic [NUM_MASTERS-1:0]            m_wre,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_ad,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_din,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              ram_oce,
    output logic                              ram_ce,
    output logic                              ram_wre,
    output logic [ADDR_WIDTH-1:0]             ram_ad,
    output logic [DATA_WIDTH-1:0]             ram_din,
    input  logic [DATA_WIDTH-1:0]             ram_dout,
    output logic                              busy
);

    localparam int TAG_W = clog2(NUM_MASTERS);

    arb_state_t             state_reg, state_next;
    logic [NUM_MASTERS-1:0] grant_reg, grant_next;
    logic [TAG_W-1:0]       owner_reg, owner_next;
    logic [TAG_W-1:0]       win_idx;
    logic                   win_found;
    logic                   tags_busy;

    // ---------------- winner selection ----------------
`ifdef BSRAM_ARB_ROUND_ROBIN_EN
    logic [TAG_W-1:0] last_reg, last_next;

    always_comb begin
        int cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            cand = (int'(last_reg) + 1 + k) % NUM_MASTERS;
            if (!win_found && m_req[cand]) begin
                win_found = 1'b1;
                win_idx   = TAG_W'(cand);
            end
        end
    end

    always_comb begin
        last_next = last_reg;
        if (state_reg == ST_IDLE && win_found) begin
            last_next = win_idx;
        end
    end

    // Resetting to the top index makes the very first search begin at master 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_reg <= TAG_W'(NUM_MASTERS - 1);
        end else begin
            last_reg <= last_next;
        end
    end
`else
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            if (!win_found && m_req[k]) begin
                win_found = 1'b1;
                win_idx   = TAG_W'(k);
            end
        end
    end
`endif

    // ---------------- ownership FSM ----------------
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        owner_next = owner_reg;
        case (state_reg)
            ST_IDLE: begin
                grant_next = '0;
                if (win_found) begin
                    grant_next = NUM_MASTERS'(1) << win_idx;
                    owner_next = win_idx;
                    state_next = ST_OWN;
                end
            end
            ST_OWN: begin
                // Release always passes through IDLE, leaving one ownerless cycle.
                if (!(|(m_req & grant_reg))) begin
                    grant_next = '0;
                    state_next = ST_IDLE;
                end
            end
            default: begin
                grant_next = '0;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            grant_reg <= '0;
            owner_reg <= '0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            owner_reg <= owner_next;
        end
    end

    // ---------------- port mux (AND-OR on the one-hot grant) ----------------
    logic [NUM_MASTERS-1:0] ce_masked;
    logic [NUM_MASTERS-1:0] wre_masked;
    logic [ADDR_WIDTH-1:0]  ad_masked  [NUM_MASTERS];
    logic [DATA_WIDTH-1:0]  din_masked [NUM_MASTERS];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_mask
            assign ce_masked[gi]  = grant_reg[gi] & m_ce[gi];
            assign wre_masked[gi] = grant_reg[gi] & m_wre[gi];
            assign ad_masked[gi]  = {ADDR_WIDTH{grant_reg[gi]}} & m_ad[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign din_masked[gi] = {DATA_WIDTH{grant_reg[gi]}} & m_din[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    always_comb begin
        ram_ad  = '0;
        ram_din = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            ram_ad  = ram_ad  | ad_masked[k];
            ram_din = ram_din | din_masked[k];
        end
    end

    assign ram_ce  = |ce_masked;
    assign ram_wre = |wre_masked;
    assign ram_oce = 1'b1;

    // ---------------- read tagging ----------------
    bsram_read_tag_pipe #(
        .DEPTH       (READ_LATENCY),
        .TAG_W       (TAG_W),
        .NUM_MASTERS (NUM_MASTERS)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (ram_ce & ~ram_wre),
        .in_tag    (owner_reg),
        .rvalid    (m_rvalid),
        .any_valid (tags_busy)
    );

    assign m_grant = grant_reg;
    assign m_rdata = ram_dout;
    assign busy    = (|grant_reg) | tags_busy;

endmodule

// File: tb/tb_bsram_port_arbiter.sv
// Directed bench for bsram_port_arbiter with a BSRAM behavioural memory and a
// transaction-level reference model checked on every falling clock edge.
module tb_bsram_port_arbiter;
    import bsram_arb_pkg::*;

    localparam int N  = 3;
    localparam int AW = 11;
    localparam int DW = 32;
    localparam int RL = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  m_req = '0;
    logic [N-1:0]  m_ce = '0;
    logic [N-1:0]  m_wre = '0;
    logic [N*AW-1:0] m_ad = '0;
    logic [N*DW-1:0] m_din = '0;
    logic [N-1:0]  m_grant, m_rvalid;
    logic [DW-1:0] m_rdata, ram_din, ram_dout;
    logic [AW-1:0] ram_ad;
    logic          ram_oce, ram_ce, ram_wre, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bsram_port_arbiter #(
        .NUM_MASTERS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LATENCY(RL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .m_req(m_req), .m_grant(m_grant),
        .m_ce(m_ce), .m_wre(m_wre), .m_ad(m_ad), .m_din(m_din),
        .m_rvalid(m_rvalid), .m_rdata(m_rdata), .ram_oce(ram_oce),
        .ram_ce(ram_ce), .ram_wre(ram_wre), .ram_ad(ram_ad),
        .ram_din(ram_din), .ram_dout(ram_dout), .busy(busy)
    );

    function automatic logic [DW-1:0] init_word(input int a);
        return 32'hA5A5_0000 | 32'(a);
    endfunction

    // ---------------- BSRAM memory model (pipeline mode) ----------------
    logic [DW-1:0] mem     [1<<AW];
    bit            written [1<<AW];
    logic [DW-1:0] rd_pipe [RL];

    always @(posedge clk) begin
        if (ram_ce && ram_wre) begin
            mem[ram_ad]     <= ram_din;
            written[ram_ad] <= 1'b1;
        end
        if (ram_ce && !ram_wre) begin
            rd_pipe[0] <= written[ram_ad] ? mem[ram_ad] : init_word(int'(ram_ad));
        end
        for (int k = 1; k < RL; k++) begin
            rd_pipe[k] <= rd_pipe[k-1];
        end
    end
    assign ram_dout = rd_pipe[RL-1];

    // ---------------- reference model ----------------
    typedef struct {
        int            due;
        int            tag;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           rq[$];
    int            own  = -1;
    int            last = N - 1;
    int            cyc  = 0;
    logic [DW-1:0] sh_mem     [1<<AW];
    bit            sh_written [1<<AW];

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            own  = -1;
            last = N - 1;
            rq.delete();
        end else begin
            int a;
            // Memory traffic issued by the owner during the cycle just ended.
            if (own >= 0 && m_ce[own]) begin
                a = int'(m_ad[own*AW +: AW]);
                if (m_wre[own]) begin
                    sh_mem[a]     = m_din[own*DW +: DW];
                    sh_written[a] = 1'b1;
                end else begin
                    rd_t r;
                    r.due  = cyc + RL;
                    r.tag  = own;
                    r.data = sh_written[a] ? sh_mem[a] : init_word(a);
                    rq.push_back(r);
                end
            end
            // Ownership rules.
            if (own < 0) begin
`ifdef BSRAM_ARB_ROUND_ROBIN_EN
                for (int k = 1; k <= N; k++) begin
                    if (own < 0 && m_req[(last + k) % N]) own = (last + k) % N;
                end
`else
                for (int k = N - 1; k >= 0; k--) begin
                    if (m_req[k]) own = k;
                end
`endif
                if (own >= 0) last = own;
            end else if (!m_req[own]) begin
                own = -1;
            end
            cyc++;
            while (rq.size() > 0 && rq[0].due < cyc) void'(rq.pop_front());
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            chk("rst_grant", 64'(m_grant), 64'(0));
            chk("rst_ce", 64'({ram_ce, ram_wre}), 64'(0));
            chk("rst_rvalid", 64'(m_rvalid), 64'(0));
            chk("rst_busy", 64'(busy), 64'(0));
        end else begin
            logic [N-1:0]  e_grant, e_rv;
            logic          e_ce, e_wre, e_busy;
            logic [AW-1:0] e_ad;
            logic [DW-1:0] e_din, e_data;
            e_grant = '0; e_ce = 1'b0; e_wre = 1'b0; e_ad = '0; e_din = '0;
            e_rv = '0; e_data = '0;
            e_busy = (own >= 0);
            if (own >= 0) begin
                e_grant[own] = 1'b1;
                e_ce  = m_ce[own];
                e_wre = m_ce[own] & m_wre[own];
                e_ad  = m_ad[own*AW +: AW];
                e_din = m_din[own*DW +: DW];
            end
            foreach (rq[k]) begin
                if (rq[k].due >= cyc) e_busy = 1'b1;
                if (rq[k].due == cyc) begin
                    e_rv[rq[k].tag] = 1'b1;
                    e_data = rq[k].data;
                end
            end
            chk("grant", 64'(m_grant), 64'(e_grant));
            chk("ram_ctl", 64'({ram_oce, ram_ce, ram_ce & ram_wre}), 64'({1'b1, e_ce, e_wre}));
            chk("ram_ad", 64'(ram_ad), 64'(e_ad));
            chk("ram_din", 64'(ram_din), 64'(e_din));
            chk("rvalid", 64'(m_rvalid), 64'(e_rv));
            if (e_rv != 0) chk("rdata", 64'(m_rdata), 64'(e_data));
            chk("busy", 64'(busy), 64'(e_busy));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int i, input logic ce, input logic wre,
                         input logic [AW-1:0] ad, input logic [DW-1:0] din);
        m_ce[i]           = ce;
        m_wre[i]          = wre;
        m_ad[i*AW +: AW]  = ad;
        m_din[i*DW +: DW] = din;
    endtask

    task automatic wait_grant(output int idx);
        idx = -1;
        for (int k = 0; k < 10 && idx < 0; k++) begin
            for (int j = 0; j < N; j++) begin
                if (m_grant[j]) idx = j;
            end
            if (idx < 0) step();
        end
        if (idx < 0) begin
            total++;
            bad++;
            $display("FAIL grant_timeout got=%0h exp=nonzero", m_grant);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    int idx;
    int exp_order[$];

    initial begin
        repeat (3) step();
        chk("reset_state", 64'({m_grant, ram_oce, ram_ce, busy}), 64'({3'b000, 1'b1, 1'b0, 1'b0}));
        rst_n = 1'b1;
        step();
        $display("tx reset released");

        // Single master: write then read back through the latency pipe.
        m_req[MASTER_FFT] = 1'b1;
        step();
        chk("grant_fft", 64'(m_grant), 64'(3'b010));
        set_m(MASTER_FFT, 1'b1, 1'b1, 11'h055, 32'hDEADBEEF);
        step();
        set_m(MASTER_FFT, 1'b1, 1'b0, 11'h055, 32'h0);
        step();
        set_m(MASTER_FFT, 1'b0, 1'b0, 11'h000, 32'h0);
        chk("rvalid_early", 64'(m_rvalid), 64'(3'b000));
        step();
        chk("rvalid_fft", 64'(m_rvalid), 64'(3'b010));
        chk("rdata_fft", 64'(m_rdata), 64'(32'hDEADBEEF));
        $display("tx single-master write/read addr=055 data=%h", m_rdata);
        m_req[MASTER_FFT] = 1'b0;
        step();
        chk("release_gap", 64'(m_grant), 64'(3'b000));

        // Simultaneous requests from a fresh reset.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
`ifdef BSRAM_ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 0};
`else
        exp_order = '{0, 1, 2};
`endif
        m_req = 3'b111;
        foreach (exp_order[g]) begin
            wait_grant(idx);
            chk("grant_order", 64'(idx), 64'(exp_order[g]));
            $display("tx contention grant %0d -> master %0d", g, idx);
            if (idx >= 0) m_req[idx] = 1'b0;
            step();
            chk("order_gap", 64'(m_grant), 64'(3'b000));
`ifdef BSRAM_ARB_ROUND_ROBIN_EN
            if (g == 0) m_req[MASTER_DEMOD] = 1'b1;
`endif
        end
        m_req = '0;
        step();

        // Owner 2 reads then releases; the data must still land at master 2.
        m_req[MASTER_OFDM] = 1'b1;
        wait_grant(idx);
        chk("grant_ofdm", 64'(idx), 64'(MASTER_OFDM));
        set_m(MASTER_OFDM, 1'b1, 1'b0, 11'h055, 32'h0);
        step();
        set_m(MASTER_OFDM, 1'b0, 1'b0, 11'h000, 32'h0);
        m_req[MASTER_OFDM]  = 1'b0;
        m_req[MASTER_DEMOD] = 1'b1;
        step();
        chk("rvalid_ofdm", 64'(m_rvalid), 64'(3'b100));
        chk("rdata_ofdm", 64'(m_rdata), 64'(32'hDEADBEEF));
        chk("handover_gap", 64'(m_grant), 64'(3'b000));
        step();
        chk("grant_demod", 64'(m_grant), 64'(3'b001));
        $display("tx handover ofdm->demod rvalid routed to ofdm");

        // Non-owner master 1 hammers 0x3FF while master 0 owns.
        for (int k = 0; k < 4; k++) begin
            set_m(MASTER_FFT, 1'b1, k[0], 11'h3FF, 32'h1234_5678 + 32'(k));
            if (k == 2) set_m(MASTER_DEMOD, 1'b1, 1'b1, 11'h0AA, 32'hCAFEF00D);
            else        set_m(MASTER_DEMOD, 1'b0, 1'b0, 11'h000, 32'h0);
            step();
        end
        set_m(MASTER_FFT, 1'b0, 1'b0, 11'h000, 32'h0);
        // Back-to-back reads by the owner.
        set_m(MASTER_DEMOD, 1'b1, 1'b0, 11'h3FF, 32'h0);
        step();
        set_m(MASTER_DEMOD, 1'b1, 1'b0, 11'h0AA, 32'h0);
        step();
        set_m(MASTER_DEMOD, 1'b0, 1'b0, 11'h000, 32'h0);
        chk("rvalid_3ff", 64'(m_rvalid), 64'(3'b001));
        chk("rdata_3ff", 64'(m_rdata), 64'(32'hA5A503FF));
        step();
        chk("rvalid_0aa", 64'(m_rvalid), 64'(3'b001));
        chk("rdata_0aa", 64'(m_rdata), 64'(32'hCAFEF00D));
        $display("tx non-owner isolation: mem[3ff] intact, b2b reads ok");

        // Reset while a read is in flight.
        set_m(MASTER_DEMOD, 1'b1, 1'b0, 11'h055, 32'h0);
        step();
        set_m(MASTER_DEMOD, 1'b0, 1'b0, 11'h000, 32'h0);
        #2;
        rst_n = 1'b0;
        m_req = '0;
        #1;
        chk("midrst_clear", 64'({m_grant, ram_ce, busy, m_rvalid}), 64'(0));
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("post_rst_rvalid", 64'(m_rvalid), 64'(3'b000));
        end
        $display("tx reset mid-read: pending rvalid dropped");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bsram_port_arbiter.md
# bsram_port_arbiter

Parametrised, registered successor to the per-RAM master multiplexer: arbitrates NUM_MASTERS masters (demodulation, fft1024, ofdm, …) onto one Gowin single-port BSRAM. Masters request ownership with a req/grant handshake instead of an externally driven select. Ownership changes only at safe boundaries. Read data is tagged through the BSRAM read latency so each master sees an rvalid strobe for its own reads only. One instance sits in front of each of sp_fft0 / sp_fft1 in top.

## Interface
- NUM_MASTERS, 3, number of requesting masters (2..8); index 0 = demodulation, 1 = fft1024, 2 = ofdm
- ADDR_WIDTH, 11, BSRAM address width
- DATA_WIDTH, 32, BSRAM data width
- READ_LATENCY, 2, cycles from ce&~wre to valid ram_dout (1 = bypass, 2 = pipeline mode)
- clk  in  1  system clock; single clock domain
- rst_n  in  1  asynchronous, active-low reset
- m_req  in  NUM_MASTERS  per-master ownership request, level
- m_grant  out  NUM_MASTERS  one-hot ownership, registered
- m_ce, m_wre  in  NUM_MASTERS each  per-master strobes
- m_ad  in  NUM_MASTERS*ADDR_WIDTH  flattened addresses, master i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- m_din  in  NUM_MASTERS*DATA_WIDTH  flattened write data
- m_rvalid  out  NUM_MASTERS  one-cycle strobe: m_rdata holds data for that master's read
- m_rdata  out  DATA_WIDTH  ram_dout broadcast to all masters
- ram_oce, ram_ce, ram_wre  out  1  to BSRAM
- ram_ad  out  ADDR_WIDTH; ram_din  out  DATA_WIDTH  to BSRAM
- ram_dout  in  DATA_WIDTH  from BSRAM
- busy  out  1  any grant active or read in flight

## Operation
- States: IDLE, OWN.
- IDLE: if any m_req high, pick a winner (see Configuration), set m_grant one-hot, go to OWN. Otherwise stay; m_grant=0.
- OWN: the owner's m_ce/m_wre/m_ad/m_din drive ram_* combinationally from the registered grant. Non-owners' inputs are ignored entirely.
- OWN, owner m_req sampled low: m_grant←0 and state←IDLE. This gives a mandatory ≥1-cycle gap with no owner. Other requests are not preempting.
- No owner: ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.
- ram_oce is constant 1, so in-flight reads complete regardless of ownership.
- Read tag pipe: READ_LATENCY stages of {valid, owner index}. Stage 0 loads valid = ram_ce & ~ram_wre.
- m_rvalid[i] = last stage valid and tag == i. Reads issued before release therefore land at the correct master after ownership moves.
- busy = |m_grant | any tag stage valid.

## Timing
- Reset values: m_grant=0, state IDLE, tag pipe cleared, all m_rvalid=0, ram_ce=ram_wre=0, ram_ad=ram_din=0, ram_oce=1, busy=0.
- Grant latency: m_req high at edge t (IDLE) → m_grant high after edge t; the master may drive m_ce in that cycle.
- Release latency: owner req low at edge t → m_grant low after t. The earliest new grant comes after edge t+1.
- Read: owner ce&~wre in cycle c → m_rvalid and data in cycle c+READ_LATENCY.
- Back-to-back reads: one rvalid per cycle.
- Write: ram_wre follows m_wre in the same cycle. No rvalid is produced.
- Simultaneous requests in IDLE: exactly one grant. Losers keep waiting with req high.
- Owner drops req while reads are in flight: the tags drain unaffected.
- Reset mid-operation: grant and tags clear immediately and asynchronously. Pending rvalids are lost.

## Configuration
- BSRAM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. Search starts at (last owner + 1) mod NUM_MASTERS. The last-owner register resets to NUM_MASTERS-1, so the first search starts at master 0.
- Not defined: fixed priority, lowest index wins. The last-owner register is not built.

## Structure
- Package bsram_arb_pkg holds:
  - state encoding (IDLE, OWN);
  - the master index constants MASTER_DEMOD=0, MASTER_FFT=1, MASTER_OFDM=2;
  - the tag width function clog2(NUM_MASTERS).
- Sub-module bsram_read_tag_pipe (parametrised depth and tag width) holds the shift register and the rvalid decode.

## Test plan
- Reset: assert rst_n=0 mid-read → m_grant=0, ram_ce=0, no m_rvalid afterwards.
- Single master: m_req[1]=1 → grant[1] next cycle. Write 0xDEADBEEF to addr 0x055, then read it → m_rvalid[1] exactly 2 cycles after the read ce, m_rdata=0xDEADBEEF.
- Simultaneous m_req=3'b111, fixed priority → grant order 0,1,2 as each releases, with a 1-cycle all-zero grant gap between each.
- Same stimulus with BSRAM_ARB_ROUND_ROBIN_EN, master 0 re-requesting immediately → order 0,1,2,0.
- Owner 2 issues a read, then drops req the next cycle. Master 0 is then granted → that rvalid goes to master 2 only. m_rvalid[0] stays 0 until master 0's own read.
- Non-owner master 1 toggles m_ce/m_wre with addr 0x3FF while master 0 owns → ram_* track master 0 only. Memory at 0x3FF is unchanged.
